// File: rtl/prog_delay_pkg.sv
// Shared helpers for the programmable delay line: port/pointer width
// computation and the delay clamp applied on every configuration load.
package prog_delay_pkg;

  function automatic int unsigned delay_w(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Zero is not a usable delay, so it maps to the shortest one.
  function automatic int unsigned clamp_delay(input int unsigned cfg,
                                              input int unsigned max_delay);
    if (cfg == 0) return 1;
    if (cfg > max_delay) return max_delay;
    return cfg;
  endfunction

endpackage

// File: rtl/prog_delay_line_sdp_ram.sv
// Simple dual-port RAM with registered read, read-first on address collision.
module sdp_ram
  import prog_delay_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-lane delay line with a runtime-programmable delay of D enabled cycles.
// The RAM read register doubles as the output register; dout is masked until valid.
module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int CHANNELS      = 2,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 10,
  localparam int DW = delay_w(MAX_DELAY)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             cfg_load,
  input  logic [DW-1:0]                    delay_cfg,
  input  logic [CHANNELS-1:0][DATA_W-1:0]  din,
  output logic [CHANNELS-1:0][DATA_W-1:0]  dout,
  output logic                             dout_valid,
  output logic [DW-1:0]                    delay_act
);

  localparam int AW = addr_w(MAX_DELAY);
  localparam int W  = CHANNELS * DATA_W;

  logic [DW-1:0] d_reg;
  logic [DW-1:0] d_new;
  logic [DW-1:0] ptr;
  logic [DW-1:0] fill;
  logic          valid;
  logic [W-1:0]  rd_data;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_wa;

  assign d_new = DW'(clamp_delay(32'(delay_cfg), MAX_DELAY));

  // A load restarts the ring at slot 0, so a coincident sample lands there.
  assign ram_we = en && !rst;
  assign ram_re = en && !rst && !cfg_load;
  assign ram_wa = cfg_load ? '0 : ptr[AW-1:0];

  sdp_ram #(
    .WIDTH (W),
    .DEPTH (MAX_DELAY)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (ram_wa),
    .wd  (din),
    .re  (ram_re),
    .ra  (ptr[AW-1:0]),
    .rd  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg <= DW'(DEFAULT_DELAY);
      ptr   <= '0;
      fill  <= '0;
      valid <= 1'b0;
    end else if (cfg_load) begin
      d_reg <= d_new;
      valid <= 1'b0;
      if (en) begin
        ptr  <= (d_new == DW'(1)) ? '0 : DW'(1);
        fill <= DW'(1);
      end else begin
        ptr  <= '0;
        fill <= '0;
      end
    end else if (en) begin
      ptr <= (ptr == d_reg - DW'(1)) ? '0 : ptr + DW'(1);
      if (fill != d_reg) fill <= fill + DW'(1);
      else valid <= 1'b1;
    end
  end

  // rd_data may hold pre-reset or pre-load samples; only a full ring unmasks it.
  assign dout       = valid ? rd_data : '0;
  assign dout_valid = valid;
  assign delay_act  = d_reg;

endmodule
